// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : core_sequencer
//  Description : Cycle sequencer for the t16q core. Drives the fetch/execute
//                phase into Decode, owns the single memory bus port for
//                instruction fetch and LDR/STR accesses, gates IR and
//                register-file commits, counts retired instructions and
//                provides halt and bus-fault control.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        halt_req,
    input  logic        fault_clr,
    input  logic        dec_mem_access,
    input  logic        dec_mem_w_en,
    input  logic [15:0] pc,
    input  logic [15:0] alu_result,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic        ph1,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic        ir_load,
    output logic        rf_we,
    output logic        ld_we,
    output logic        pc_load,
    output logic [15:0] pc_load_val,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]  r_state;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_instret;

    logic [2:0]  w_state_nxt;
    logic [2:0]  w_retire_nxt;
    logic        w_retire;
    logic        w_bus_phase;
    logic        w_ack_ok;
    logic        w_ack_err;
    logic        w_timeout;

    // Bus-phase qualifiers; an ack outside FETCH/MEM is simply not looked at
    always_comb begin
        w_bus_phase = (r_state == S_FETCH) || (r_state == S_MEM);
        w_ack_ok    = w_bus_phase && bus_ack && !bus_err;
        w_ack_err   = w_bus_phase && bus_ack && bus_err;
        w_timeout   = w_bus_phase && !bus_ack && (r_wait_cnt == (TIMEOUT - 8'd1));
        // Halt wins over stop, stop wins over continuing
        if (halt_req) begin
            w_retire_nxt = S_HALTED;
        end else if (!run) begin
            w_retire_nxt = S_IDLE;
        end else begin
            w_retire_nxt = S_FETCH;
        end
    end

    // Outputs decoded from state and bus_ack, plus next-state selection
    always_comb begin
        ph1         = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = 16'h0000;
        ir_load     = 1'b0;
        rf_we       = 1'b0;
        ld_we       = 1'b0;
        pc_load     = 1'b0;
        w_retire    = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    pc_load     = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                ph1      = 1'b1;
                bus_req  = 1'b1;
                bus_addr = pc;
                if (w_ack_ok) begin
                    // IR capture and the PC += 2 writeback happen together
                    ir_load     = 1'b1;
                    rf_we       = 1'b1;
                    w_state_nxt = S_EXEC;
                end else if (w_ack_err || w_timeout) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_EXEC: begin
                if (dec_mem_access) begin
                    w_state_nxt = S_MEM;
                end else begin
                    rf_we       = 1'b1;
                    w_retire    = 1'b1;
                    w_state_nxt = w_retire_nxt;
                end
            end
            S_MEM: begin
                bus_req  = 1'b1;
                bus_we   = dec_mem_w_en;
                bus_addr = alu_result;
                if (w_ack_ok) begin
                    ld_we       = !dec_mem_w_en;
                    w_retire    = 1'b1;
                    w_state_nxt = w_retire_nxt;
                end else if (w_ack_err || w_timeout) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_HALTED: begin
                if (!halt_req) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, bus wait counter and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_instret  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM)) && (w_state_nxt != r_state)) begin
                r_wait_cnt <= 8'd0;
            end else if (bus_req && !bus_ack) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign pc_load_val = RESET_PC;
    assign halted      = (r_state == S_HALTED);
    assign fault       = (r_state == S_FAULT);
    assign instret     = r_instret;

endmodule
`default_nettype wire
